// File: rtl/regf_pkg.sv
// Shared state type and sizing/slicing helpers for the sweep-cleared register file.
package regf_pkg;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SWEEP = 1'b1
  } regf_state_e;

  function automatic int unsigned addr_width(input int unsigned nreg);
    return (nreg > 1) ? $clog2(nreg) : 1;
  endfunction

  // LSB position of port `port` inside a packed multi-port bus of `width`-bit lanes.
  function automatic int unsigned slice_lo(input int unsigned width, input int unsigned port);
    return width * port;
  endfunction

endpackage

// File: rtl/regf_sweep_sb_if.sv
// Decode/writeback-facing bus of the register file: reads, writeback, issue marking, clear.
interface regf_sweep_sb_if #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned NREG = 32,
  parameter int unsigned NRD  = 2
);
  import regf_pkg::*;

  localparam int unsigned AW = addr_width(NREG);

  logic                 rd_en;
  logic [NRD*AW-1:0]    rd_addr;
  logic [NRD*XLEN-1:0]  rd_data;
  logic [NRD-1:0]       rd_pend;
  logic                 wr_en;
  logic [AW-1:0]        wr_addr;
  logic [XLEN-1:0]      wr_data;
  logic                 iss_en;
  logic [AW-1:0]        iss_addr;
  logic                 clr_req;
  logic                 busy;

  modport master (
    output rd_en, rd_addr, wr_en, wr_addr, wr_data, iss_en, iss_addr, clr_req,
    input  rd_data, rd_pend, busy
  );

  modport slave (
    input  rd_en, rd_addr, wr_en, wr_addr, wr_data, iss_en, iss_addr, clr_req,
    output rd_data, rd_pend, busy
  );

endinterface

// File: rtl/regf_scoreboard.sv
// Per-register pending bits: set on issue, cleared on writeback, flushed on reset/clear.
module regf_scoreboard
  import regf_pkg::*;
#(
  parameter int unsigned NREG = 32,
  parameter int unsigned NRD  = 2,
  parameter int unsigned AW   = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              set_en,
  input  logic [AW-1:0]     set_addr,
  input  logic              clr_en,
  input  logic [AW-1:0]     clr_addr,
  input  logic [NRD*AW-1:0] lk_addr,
  output logic [NRD-1:0]    lk_pend
);

  logic [NREG-1:0] pend_q, pend_d;

  // Set is applied after clear so a same-cycle issue supersedes the retiring write.
  always_comb begin
    pend_d = pend_q;
    if (clr_en) pend_d[clr_addr] = 1'b0;
    if (set_en) pend_d[set_addr] = 1'b1;
    if (flush)  pend_d = '0;
  end

  always_ff @(posedge clk) begin
    if (!rst) pend_q <= '0;
    else      pend_q <= pend_d;
  end

  for (genvar p = 0; p < NRD; p++) begin : g_lk
    assign lk_pend[p] = pend_q[lk_addr[slice_lo(AW, p) +: AW]];
  end

endmodule

// File: rtl/regf_sweep_sb.sv
// Multi-port integer register file with write bypass, pending scoreboard and a
// one-entry-per-cycle clear sweep so the data array needs no wide reset.
module regf_sweep_sb
  import regf_pkg::*;
#(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned NREG   = 32,
  parameter int unsigned NRD    = 2,
  parameter int unsigned BYPASS = 1
) (
  input logic           clk,
  input logic           rst,
  regf_sweep_sb_if.slave bus
);

  localparam int unsigned   AW      = addr_width(NREG);
  localparam logic [AW-1:0] LastIdx = AW'(NREG - 1);

  regf_state_e     state_q, state_d;
  logic [AW-1:0]   idx_q, idx_d;
  logic            flush;
  logic            sweeping;
  logic            busy;
  logic            wr_ok;
  logic            iss_ok;
  logic [NRD-1:0]  sb_pend;

  logic [XLEN-1:0] mem [NREG];
  logic            mem_we;
  logic [AW-1:0]   mem_waddr;
  logic [XLEN-1:0] mem_wdata;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    flush   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.clr_req) begin
          state_d = SWEEP;
          idx_d   = AW'(1);
          flush   = 1'b1;
        end
      end
      SWEEP: begin
        if (idx_q == LastIdx) state_d = IDLE;
        else                  idx_d   = idx_q + AW'(1);
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= SWEEP;
      idx_q   <= AW'(1);
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  assign sweeping = (state_q == SWEEP);
  // Reset cycle reports busy as well, so decode never sees stale array data.
  assign busy     = !rst || sweeping;
  assign bus.busy = busy;
  assign wr_ok    = !busy && bus.wr_en  && (bus.wr_addr  != '0);
  assign iss_ok   = !busy && bus.iss_en && (bus.iss_addr != '0);

  // Single array write port shared between the sweep and writeback.
  assign mem_we    = sweeping || wr_ok;
  assign mem_waddr = sweeping ? idx_q : bus.wr_addr;
  assign mem_wdata = sweeping ? '0    : bus.wr_data;

  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
  end

  regf_scoreboard #(
    .NREG (NREG),
    .NRD  (NRD),
    .AW   (AW)
  ) u_sb (
    .clk      (clk),
    .rst      (rst),
    .flush    (flush),
    .set_en   (iss_ok),
    .set_addr (bus.iss_addr),
    .clr_en   (wr_ok),
    .clr_addr (bus.wr_addr),
    .lk_addr  (bus.rd_addr),
    .lk_pend  (sb_pend)
  );

  for (genvar p = 0; p < NRD; p++) begin : g_rd
    logic [AW-1:0]   addr;
    logic            hit;
    logic [XLEN-1:0] data;
    logic            pend;

    assign addr = bus.rd_addr[slice_lo(AW, p) +: AW];
    assign hit  = (BYPASS != 0) && wr_ok && (bus.wr_addr == addr);

    always_comb begin
      data = '0;
      pend = 1'b0;
      if (bus.rd_en && !busy && (addr != '0)) begin
        if (hit) begin
          data = bus.wr_data;
        end else begin
          data = mem[addr];
          pend = sb_pend[p];
        end
      end
    end

    assign bus.rd_data[slice_lo(XLEN, p) +: XLEN] = data;
    assign bus.rd_pend[p]                         = pend;
  end

endmodule

// File: doc/regf_sweep_sb.md
# regf_sweep_sb

Parametrised integer register file for the RISC-V core, replacing the fixed 32x32 two-read/one-write file. It adds a configurable number of read ports, write-to-read bypass, and a per-register pending scoreboard for the decode stage. It also has a sequential clear engine that zeroes one entry per cycle, so the storage array carries no wide reset and can map to distributed RAM. It sits between decode (reads, issue marking) and writeback (writes).

## Interface
- XLEN, 32: register data width.
- NREG, 32: register count, power of two, 4..64; AW = log2(NREG).
- NRD, 2: read port count, 1..4.
- BYPASS, 1: 1 = same-cycle write data forwarded to reads; 0 = reads see array only.
- clk  in  1  single clock, rising edge.
- rst  in  1  reset is synchronous and active-low; 0 = reset.
- rd_en  in  1  read enable for all ports; 0 forces every rd_data to 0.
- rd_addr  in  NRD*AW  packed read addresses, port p at [p*AW +: AW].
- rd_data  out  NRD*XLEN  packed read data, combinational.
- rd_pend  out  NRD  port p source has a pending writer.
- wr_en  in  1  writeback strobe.
- wr_addr  in  AW  writeback destination.
- wr_data  in  XLEN  writeback data.
- iss_en  in  1  instruction issued with destination iss_addr.
- iss_addr  in  AW  destination to mark pending.
- clr_req  in  1  one-cycle pulse requesting a full clear.
- busy  out  1  clear sweep in progress.

## Operation
- Entry 0 is hardwired: reads of address 0 return 0, rd_pend 0; writes and issues to 0 are dropped.
- FSM states are IDLE and SWEEP, with a sweep index idx (AW bits).
  - rst=0: state to SWEEP, idx to 1, all pending bits cleared. The data array is not reset directly.
  - SWEEP: each cycle writes 0 to entry idx and increments idx. On idx == NREG-1 the entry is written and the FSM returns to IDLE.
  - IDLE with clr_req=1: go to SWEEP, idx=1, pending cleared.
  - clr_req in SWEEP is ignored; it does not restart the sweep.
- While busy=1:
  - wr_en and iss_en are ignored.
  - rd_data = 0 and rd_pend = 0 on every port.
- Write: when wr_en, wr_addr!=0 and IDLE, the entry is updated at the rising edge and its pending bit is cleared.
- Issue: when iss_en, iss_addr!=0 and IDLE, the pending bit is set.
  - If wr_addr == iss_addr in the same cycle, the issue wins and the bit ends set, because the new producer supersedes.
- Read port p (IDLE, rd_en=1):
  - If BYPASS, wr_en, and wr_addr == rd_addr[p] != 0: rd_data = wr_data and rd_pend = 0.
  - Otherwise rd_data = array[rd_addr[p]] and rd_pend = pending[rd_addr[p]].
  - iss_en in the same cycle does not affect that cycle's rd_pend.
- rd_en=0: rd_data = 0 and rd_pend = 0. No latch may be inferred.

## Timing
- Reset values: busy=1, rd_data=0, rd_pend=0 for the reset cycle and all sweep cycles.
- After rst returns high, busy stays 1 for NREG-1 clean cycles; first write is accepted in cycle NREG-1 after release (31 for default).
- Write latency 1 cycle (0 with BYPASS); issue-to-rd_pend latency 1 cycle.
- Reset asserted mid-sweep: restarts from idx=1.
- idx never exceeds NREG-1; no wrap-around.

## Structure
- Package regf_pkg:
  - state enum {IDLE, SWEEP};
  - clog2-based AW helper;
  - packed-port slice helper function.
- Sub-module regf_scoreboard holds the NREG pending bits with set/clear/flush logic and NRD lookup ports; the top instantiates it once.
- Data array is an unreset reg array with exactly one write port muxed between sweep and writeback.

## Test plan
- Reset then idle: rst=0 for 2 cycles, release -> busy=1 for exactly 31 cycles, then 0; all 31 entries read 0.
- Write/read with bypass: write x5=0xDEADBEEF while port 0 reads x5 -> rd_data0=0xDEADBEEF same cycle; next cycle array value matches. With BYPASS=0 the same-cycle read returns 0.
- x0 rules: write 0x1234 to x0, issue x0 -> reads of x0 give 0 and rd_pend=0.
- Scoreboard collision: issue x7, then next cycle write x7 together with issue x7 -> rd_pend for x7 stays 1; a lone write next cycle -> 0.
- clr_req after loading x1..x31 = index values -> busy for 31 cycles, all entries 0, pending cleared. A second clr_req at sweep cycle 10 does not lengthen it.
- Mid-sweep reset at idx=12 -> sweep restarts at idx 1, full 31 cycles after release. A parameter run with NREG=16, NRD=4 shows 15-cycle sweep and independent 4-port reads.
